alu_sched: RTL and testbench
============================

# alu_sched

Two-requester scheduler that shares the single combinational `alu` (opcodes 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 sll, 0111 srl) between two clients.
- Arbitrates round-robin and registers the granted operation onto the ALU inputs.
- Captures the ALU result one cycle later.
- Returns it through a valid/ready response port tagged with the requester id.
- Sits between the ALU and its users (decode/issue logic, test sequencers); exactly one operation is in flight at a time.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; a request is taken when `req_valid[i] & req_ready[i]`.
- `req0_opcode`, `req1_opcode`  in  4  requested operation.
- `req0_operand1`, `req1_operand1`  in  WIDTH  first operand.
- `req0_operand2`, `req1_operand2`  in  WIDTH  second operand.
- `alu_opcode`  out  4  registered, to ALU `opcode`.
- `alu_operand1`, `alu_operand2`  out  WIDTH  registered, to ALU operands.
- `alu_result`  in  WIDTH  from ALU `result`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester index of the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_err`  out  1  illegal-opcode flag; see Configuration.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - `req_ready` is combinational and one-hot on the grant. Requester `prio` wins if valid; otherwise the other requester wins if valid. No valid requester gives `req_ready = 2'b00`.
  - On accept, the winner's opcode and operands are latched into `alu_*`, its index is latched into `rsp_id`, and the FSM goes to EXEC.
- EXEC: `alu_result` is captured into `rsp_result`, `rsp_valid` is set to 1 and the FSM goes to RESP. `req_ready = 0`.
- RESP: `rsp_valid` is held with stable `rsp_id`, `rsp_result` and `rsp_err` until `rsp_ready = 1`. On that handshake:
  - `rsp_valid` clears.
  - `prio` becomes `~rsp_id`.
  - The FSM returns to IDLE.
- Requesters hold `req_valid` and their fields stable until accepted. The scheduler never drops an accepted request except on reset.
- `alu_*` outputs hold their last issued values outside EXEC. They change only on accept.
- Width: `rsp_result` is `alu_result` verbatim. The scheduler performs no arithmetic.

## Timing
- Reset values:
  - FSM = IDLE, `prio = 0`.
  - `req_ready = 2'b00` during the reset cycle.
  - `alu_opcode = 4'b0000`, `alu_operand1 = alu_operand2 = 0`.
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_result = 0`, `rsp_err = 0`.
- Latency: accept on edge N, `rsp_valid = 1` after edge N+2 (visible in cycle N+2).
- Peak throughput: one operation per 3 cycles with `rsp_ready` held high. The next accept can occur in the same cycle as the response handshake is seen at IDLE, i.e. cycle N+3.
- Simultaneous `req_valid = 2'b11`: grant goes to `prio`. Both held continuously yields strict alternation 0,1,0,1…
- A response stalled by `rsp_ready = 0` blocks all new accepts. `req_ready` stays 0.
- `rst` asserted in any state aborts the in-flight operation on that edge with no response. All registers take their reset values.
- `rsp_ready` asserted while `rsp_valid = 0` is ignored.

## Configuration
- Macro: `ALU_SCHED_OPCHECK_EN`.
- Defined: opcodes outside 0001–0111 are legal to accept but are never issued to the ALU. On accept:
  - `alu_*` are left unchanged.
  - The FSM goes directly to RESP with `rsp_err = 1`, `rsp_result = 0` and `rsp_valid` visible in cycle N+1.
  - Legal opcodes keep `rsp_err = 0` and 2-cycle latency.
- Undefined: every opcode is issued and handled identically. `rsp_err` is tied to 0.

## Test plan
- Add: after reset, requester 0 sends opcode 0001 with operand1 50, operand2 10 and `rsp_ready` held high. Required: accept in cycle N, then `rsp_valid` with `rsp_id = 0` and `rsp_result = 60` in cycle N+2, then IDLE.
- Contention: both requesters valid from reset. Requester 0 sends 0010 (50, 10); requester 1 sends 0110 (50, 10). Required: requester 0 is served first (result 40), then requester 1 (result 51200, `rsp_id = 1`). Continuing both yields alternation.
- Back-pressure: requester 1 sends 0101 (50, 10) with `rsp_ready = 0` for 5 cycles. Required: `rsp_valid = 1`, `rsp_result = 56` and `rsp_id = 1` held stable. `req_ready = 00` even when `req_valid = 01`. The next accept occurs only after the handshake.
- Reset mid-operation: assert `rst` in EXEC. Required: no response appears, all outputs return to reset values and the next accept grants requester 0.
- `ALU_SCHED_OPCHECK_EN` defined: opcode 1000 is sent. Required: `rsp_err = 1` and `rsp_result = 0` at N+1, `alu_opcode` is unchanged. With the macro undefined, the same stimulus gives `rsp_err = 0` at N+2 with `rsp_result = alu_result`.
- Full opcode sweep for 0011, 0100 and 0111 with operands 50 and 10. Required results: 2, 58 and 0.

Source files
------------

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Optional ALU_SCHED_OPCHECK_EN: illegal opcodes bypass the ALU and return rsp_err.
module alu_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_operand1,
    input  logic [WIDTH-1:0] req0_operand2,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_operand1,
    input  logic [WIDTH-1:0] req1_operand2,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             prio;
    logic             grant_id;
    logic             accept;
    logic [3:0]       grant_opcode;
    logic [WIDTH-1:0] grant_operand1;
    logic [WIDTH-1:0] grant_operand2;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_ready = 2'b00;
        grant_id  = prio;
        accept    = 1'b0;
        if (state == IDLE && !rst) begin
            grant_id            = req_valid[prio] ? prio : ~prio;
            accept              = req_valid[grant_id];
            req_ready[grant_id] = req_valid[grant_id];
        end
    end

    assign grant_opcode   = grant_id ? req1_opcode   : req0_opcode;
    assign grant_operand1 = grant_id ? req1_operand1 : req0_operand1;
    assign grant_operand2 = grant_id ? req1_operand2 : req0_operand2;

`ifdef ALU_SCHED_OPCHECK_EN
    logic illegal;
    assign illegal = (grant_opcode == 4'd0) || (grant_opcode > 4'd7);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SCHED_OPCHECK_EN
                    state_next = illegal ? RESP : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio         <= 1'b0;
            alu_opcode   <= 4'b0000;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
`ifdef ALU_SCHED_OPCHECK_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id <= grant_id;
`ifdef ALU_SCHED_OPCHECK_EN
                        if (illegal) begin
                            // Illegal opcode never reaches the ALU; answer next cycle.
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_valid  <= 1'b1;
                        end else begin
                            rsp_err      <= 1'b0;
                            alu_opcode   <= grant_opcode;
                            alu_operand1 <= grant_operand1;
                            alu_operand2 <= grant_operand2;
                        end
`else
                        alu_opcode   <= grant_opcode;
                        alu_operand1 <= grant_operand1;
                        alu_operand2 <= grant_operand2;
`endif
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_SCHED_OPCHECK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: behavioural ALU, directed scenarios and random traffic.
// Honours ALU_SCHED_OPCHECK_EN for the illegal-opcode scenario.
module tb_alu_sched;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req0_opcode, req1_opcode;
    logic [W-1:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_operand1, alu_operand2, alu_result;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0] rsp_result;

    int checks = 0;
    int errors = 0;

    alu_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_opcode(req0_opcode), .req0_operand1(req0_operand1), .req0_operand2(req0_operand2),
        .req1_opcode(req1_opcode), .req1_operand1(req1_operand1), .req1_operand2(req1_operand2),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    // The shared combinational ALU the scheduler drives.
    always_comb alu_result = ref_alu(alu_opcode, alu_operand1, alu_operand2);

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one request, wait for accept and the response; reports what was observed.
    task automatic issue(input logic id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int wt, output int lat, output logic [W-1:0] res, output logic rid,
                         output logic err, output logic [3:0] aop, output logic [W-1:0] aa, output logic [W-1:0] ab);
        bit accepted = 0;
        wt = -1; lat = -1; res = '0; rid = 1'b0; err = 1'b0; aop = '0; aa = '0; ab = '0;
        if (id) begin req1_opcode = op; req1_operand1 = a; req1_operand2 = b; end
        else    begin req0_opcode = op; req0_operand1 = a; req0_operand2 = b; end
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin accepted = 1; wt = k; break; end
        end
        @(posedge clk); #1 req_valid[id] = 1'b0;
        if (!accepted) return;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k; res = rsp_result; rid = rsp_id; err = rsp_err;
                aop = alu_opcode; aa = alu_operand1; ab = alu_operand2;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
        req0_opcode = 4'd1; req0_operand1 = 5; req0_operand2 = 6;
        req1_opcode = 4'd2; req1_operand1 = 7; req1_operand2 = 8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_flags: got valid=%b id=%b err=%b expected 0 0 0", rsp_valid, rsp_id, rsp_err); end
        checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result: got %0d expected 0", rsp_result); end
        checks++; if (alu_opcode !== 4'd0 || alu_operand1 !== '0 || alu_operand2 !== '0) begin errors++;
            $display("FAIL reset_alu: got op=%0d a=%0d b=%0d expected 0 0 0", alu_opcode, alu_operand1, alu_operand2); end
        @(posedge clk); #1 req_valid = 2'b00; rst = 1'b0;
    endtask

    task automatic test_add();
        int wt, lat; logic [W-1:0] res, aa, ab; logic rid, err; logic [3:0] aop;
        issue(1'b0, 4'd1, 50, 10, wt, lat, res, rid, err, aop, aa, ab);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (res !== 60) begin errors++; $display("FAIL add_result: got %0d expected 60", res); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL add_id: got %0d expected 0", rid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err: got %0d expected 0", err); end
    endtask

    task automatic test_opcode_sweep();
        logic [3:0] ops [3] = '{4'd3, 4'd4, 4'd7};
        logic [W-1:0] exp [3] = '{32'd2, 32'd58, 32'd0};
        int wt, lat; logic [W-1:0] res, aa, ab; logic rid, err; logic [3:0] aop;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, ops[i], 50, 10, wt, lat, res, rid, err, aop, aa, ab);
            checks++; if (wt !== 0) begin errors++; $display("FAIL sweep_accept_wait op%0d: got %0d expected 0", ops[i], wt); end
            checks++; if (lat !== 2 || res !== exp[i]) begin errors++;
                $display("FAIL sweep_result op%0d: got lat=%0d res=%0d expected lat=2 res=%0d", ops[i], lat, res, exp[i]); end
            checks++; if (aop !== ops[i]) begin errors++; $display("FAIL sweep_alu_opcode: got %0d expected %0d", aop, ops[i]); end
        end
    endtask

    // Both requesters held valid: strict alternation starting with 0, one accept every 3 cycles.
    task automatic test_contention();
        int n_acc = 0, n_rsp = 0, last_acc = -1;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_opcode = 4'd2; req0_operand1 = 50; req0_operand2 = 10;
        req1_opcode = 4'd6; req1_operand1 = 50; req1_operand2 = 10;
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 60 && n_rsp < 6; cyc++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                checks++; if (req_ready !== ((n_acc % 2 == 0) ? 2'b01 : 2'b10)) begin errors++;
                    $display("FAIL contention_grant #%0d: got %b expected %b", n_acc, req_ready, (n_acc % 2 == 0) ? 2'b01 : 2'b10); end
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc !== 3) begin errors++;
                        $display("FAIL back_to_back_spacing: got %0d cycles expected 3", cyc - last_acc); end
                end
                last_acc = cyc; n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++; if (rsp_id !== n_rsp[0] || rsp_result !== (n_rsp[0] ? 32'd51200 : 32'd40)) begin errors++;
                    $display("FAIL contention_rsp #%0d: got id=%0d res=%0d expected id=%0d res=%0d",
                             n_rsp, rsp_id, rsp_result, n_rsp[0], n_rsp[0] ? 51200 : 40); end
                n_rsp++;
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        checks++; if (n_rsp !== 6) begin errors++; $display("FAIL contention_count: got %0d responses expected 6", n_rsp); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit found = 0;
        do_reset();
        req1_opcode = 4'd5; req1_operand1 = 50; req1_operand2 = 10;
        req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (req_ready[1]) begin found = 1; break; end end
        checks++; if (!found) begin errors++; $display("FAIL bp_accept: got no accept expected accept of requester 1"); end
        @(posedge clk); #1;
        req0_opcode = 4'd1; req0_operand1 = 50; req0_operand2 = 10;
        req_valid = 2'b01;
        found = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (rsp_valid) begin found = 1; break; end end
        checks++; if (!found) begin errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid expected rsp_valid"); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 56) begin errors++;
                $display("FAIL bp_hold: got valid=%b id=%b res=%0d expected 1 1 56", rsp_valid, rsp_id, rsp_result); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready: got %b expected 00", req_ready); end
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake_cycle: got %b expected 00", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_accept: got %b expected 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        found = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (rsp_valid) begin found = 1; break; end end
        checks++; if (!found || rsp_result !== 60 || rsp_id !== 1'b0) begin errors++;
            $display("FAIL bp_followup: got found=%0d res=%0d id=%0d expected 1 60 0", found, rsp_result, rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int wt, lat; logic [W-1:0] res, aa, ab; logic rid, err; logic [3:0] aop;
        bit found = 0, seen_rsp = 0;
        do_reset();
        issue(1'b0, 4'd1, 1, 2, wt, lat, res, rid, err, aop, aa, ab);
        req1_opcode = 4'd1; req1_operand1 = 7; req1_operand2 = 8;
        req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (req_ready[1]) begin found = 1; break; end end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_accept: got no accept expected accept"); end
        @(posedge clk); #1 req_valid = 2'b00; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (rsp_result !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL rstmid_rsp_regs: got res=%0d id=%b err=%b expected 0 0 0", rsp_result, rsp_id, rsp_err); end
        checks++; if (alu_opcode !== 4'd0 || alu_operand1 !== '0 || alu_operand2 !== '0) begin errors++;
            $display("FAIL rstmid_alu: got op=%0d a=%0d b=%0d expected 0 0 0", alu_opcode, alu_operand1, alu_operand2); end
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) seen_rsp = 1;
            @(negedge clk);
        end
        checks++; if (seen_rsp) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_valid=1 expected 0"); end
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_prio: got %b expected 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        int wt, lat; logic [W-1:0] res, aa, ab; logic rid, err; logic [3:0] aop, prev_op;
        issue(1'b1, 4'd5, 3, 12, wt, lat, res, rid, err, aop, aa, ab);
        prev_op = 4'd5;
        issue(1'b0, 4'd8, 50, 10, wt, lat, res, rid, err, aop, aa, ab);
`ifdef ALU_SCHED_OPCHECK_EN
        checks++; if (lat !== 1 || err !== 1'b1 || res !== '0) begin errors++;
            $display("FAIL illegal_rsp: got lat=%0d err=%b res=%0d expected 1 1 0", lat, err, res); end
        checks++; if (aop !== prev_op) begin errors++; $display("FAIL illegal_alu_opcode: got %0d expected %0d", aop, prev_op); end
`else
        checks++; if (lat !== 2 || err !== 1'b0 || res !== ref_alu(4'd8, 50, 10)) begin errors++;
            $display("FAIL illegal_rsp: got lat=%0d err=%b res=%0d expected 2 0 %0d", lat, err, res, ref_alu(4'd8, 50, 10)); end
        checks++; if (aop !== 4'd8) begin errors++; $display("FAIL illegal_alu_opcode: got %0d expected 8", aop); end
`endif
        issue(1'b0, 4'd2, 9, 4, wt, lat, res, rid, err, aop, aa, ab);
        checks++; if (lat !== 2 || err !== 1'b0 || res !== 5) begin errors++;
            $display("FAIL illegal_recover: got lat=%0d err=%b res=%0d expected 2 0 5", lat, err, res); end
    endtask

    task automatic test_random();
        int wt, lat; logic [W-1:0] res, aa, ab; logic rid, err; logic [3:0] aop;
        for (int i = 0; i < 25; i++) begin
            logic id = 1'($urandom_range(0, 1));
            logic [3:0] op = 4'($urandom_range(1, 7));
            logic [W-1:0] a = $urandom, b = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(id, op, a, b, wt, lat, res, rid, err, aop, aa, ab);
            checks++; if (lat !== 2 || rid !== id || err !== 1'b0) begin errors++;
                $display("FAIL random_meta #%0d: got lat=%0d id=%b err=%b expected 2 %b 0", i, lat, rid, err, id); end
            checks++; if (res !== ref_alu(op, a, b)) begin errors++;
                $display("FAIL random_result #%0d op%0d: got %h expected %h", i, op, res, ref_alu(op, a, b)); end
            checks++; if (aop !== op || aa !== a || ab !== b) begin errors++;
                $display("FAIL random_alu_inputs #%0d: got %0d %h %h expected %0d %h %h", i, aop, aa, ab, op, a, b); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_opcode = '0; req0_operand1 = '0; req0_operand2 = '0;
        req1_opcode = '0; req1_operand1 = '0; req1_operand2 = '0;
        test_reset();
        test_add();
        test_opcode_sweep();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
